// File: rtl/hv_fusion_ngram_encoder_pkg.sv
// Shared constants, state encoding and sizing helpers for the n-gram encoder.
// No logic of its own; pure compile-time definitions.
// Used by the encoder top and by the associative memory sizing.
package hv_fusion_ngram_encoder_pkg;

  localparam int HV_DIMENSION_DEF = 2000;
  localparam int NGRAM_SIZE_DEF   = 3;

  typedef enum logic {
    ACCUMULATE    = 1'b0,
    OUTPUT_STABLE = 1'b1
  } state_e;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Sample counter width; a 1-sample window still needs one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = ceil_log2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hv_majority3.sv
// Bitwise 3-input majority of three equal-width hypervectors.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state, no handshake.
module hv_majority3 #(
  parameter int WIDTH = 8
) (
  input  logic [0:WIDTH-1] a_i,
  input  logic [0:WIDTH-1] b_i,
  input  logic [0:WIDTH-1] c_i,
  output logic [0:WIDTH-1] maj_o
);

  // Each bit is set when at least two of the three inputs agree on 1.
  always_comb begin
    maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

// File: rtl/hv_fusion_ngram_encoder.sv
// Fuses three modality hypervectors by majority, binds NGRAM_SIZE samples by rotate-and-XOR.
// Latency: ValidOut_SO rises the cycle after the NGRAM_SIZE-th accepted sample.
// Backpressure: output held stable until ReadyIn_SI; ReadyOut_SO is low while an n-gram waits.
module hv_fusion_ngram_encoder #(
  parameter int HV_DIMENSION = hv_fusion_ngram_encoder_pkg::HV_DIMENSION_DEF,
  parameter int NGRAM_SIZE   = hv_fusion_ngram_encoder_pkg::NGRAM_SIZE_DEF
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_mod1_DI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_mod2_DI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_mod3_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

  import hv_fusion_ngram_encoder_pkg::*;

  localparam int            CW       = cnt_width(NGRAM_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(NGRAM_SIZE - 1);

  state_e                  state_q, state_d;
  logic [0:HV_DIMENSION-1] acc_q, acc_d;
  logic [0:HV_DIMENSION-1] hv_out_q, hv_out_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [0:HV_DIMENSION-1] fused;
  logic [0:HV_DIMENSION-1] acc_rho;
  logic [0:HV_DIMENSION-1] acc_next;
  logic                    accept;

  hv_majority3 #(
    .WIDTH (HV_DIMENSION)
  ) u_majority (
    .a_i   (HypervectorIn_mod1_DI),
    .b_i   (HypervectorIn_mod2_DI),
    .c_i   (HypervectorIn_mod3_DI),
    .maj_o (fused)
  );

  // One-position rotate towards higher indices; the last bit wraps to index 0.
  always_comb begin
    acc_rho    = '0;
    acc_rho[0] = acc_q[HV_DIMENSION-1];
    for (int k = 1; k < HV_DIMENSION; k++) begin
      acc_rho[k] = acc_q[k-1];
    end
    acc_next = acc_rho ^ fused;
  end

  // Handshake flags come from the state register only, never from inputs.
  always_comb begin
    ReadyOut_SO       = (state_q == ACCUMULATE);
    ValidOut_SO       = (state_q == OUTPUT_STABLE);
    HypervectorOut_DO = hv_out_q;
    accept            = ValidIn_SI & ReadyOut_SO;
  end

  // Next-state: accumulate until the window fills, then park the result until taken.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hv_out_d = hv_out_q;
    case (state_q)
      ACCUMULATE: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            hv_out_d = acc_next;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = OUTPUT_STABLE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUTPUT_STABLE: begin
        if (ReadyIn_SI) state_d = ACCUMULATE;
      end
    endcase
  end

  // State, accumulator, counter and output register; reset discards any partial or pending n-gram.
  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state_q  <= ACCUMULATE;
      acc_q    <= '0;
      cnt_q    <= '0;
      hv_out_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hv_out_q <= hv_out_d;
    end
  end

endmodule

// File: tb/tb_hv_fusion_ngram_encoder.sv
// Bench for the n-gram encoder: three instances with NGRAM_SIZE 1, 2 and 3 at width 8.
// A per-instance reference model pushes each expected n-gram when its last sample is accepted
// and pops it when the instance hands the n-gram over.
module tb_hv_fusion_ngram_encoder;

  localparam int D = 8;

  logic clk;
  logic rst_n;

  logic         vin [3];
  logic         rin [3];
  logic [0:D-1] m1  [3];
  logic [0:D-1] m2  [3];
  logic [0:D-1] m3  [3];
  logic         rdy [3];
  logic         vout[3];
  logic [0:D-1] hv  [3];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [0:D-1] rho8(input logic [0:D-1] x);
    logic [0:D-1] r;
    r[0] = x[D-1];
    for (int k = 1; k < D; k++) r[k] = x[k-1];
    return r;
  endfunction

  function automatic logic [0:D-1] maj8(input logic [0:D-1] a, input logic [0:D-1] b,
                                        input logic [0:D-1] c);
    logic [0:D-1] r;
    for (int k = 0; k < D; k++) r[k] = (a[k] + b[k] + c[k]) >= 2;
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int N = g + 1;

    logic [0:D-1] exp_q[$];
    logic [0:D-1] acc_m;
    int           cnt_m;
    logic         st_m;

    hv_fusion_ngram_encoder #(
      .HV_DIMENSION (D),
      .NGRAM_SIZE   (N)
    ) u_dut (
      .Clk_CI                (clk),
      .Reset_RI              (rst_n),
      .ValidIn_SI            (vin[g]),
      .ReadyOut_SO           (rdy[g]),
      .HypervectorIn_mod1_DI (m1[g]),
      .HypervectorIn_mod2_DI (m2[g]),
      .HypervectorIn_mod3_DI (m3[g]),
      .ValidOut_SO           (vout[g]),
      .ReadyIn_SI            (rin[g]),
      .HypervectorOut_DO     (hv[g])
    );

    initial begin
      acc_m = '0;
      cnt_m = 0;
      st_m  = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk($sformatf("d%0d_rst_rdy", g), 32'(rdy[g]), 32'd1);
          chk($sformatf("d%0d_rst_vld", g), 32'(vout[g]), 32'd0);
          chk($sformatf("d%0d_rst_hv", g), 32'(hv[g]), 32'd0);
          acc_m = '0;
          cnt_m = 0;
          st_m  = 1'b0;
          exp_q.delete();
        end else begin
          chk($sformatf("d%0d_rdy", g), 32'(rdy[g]), 32'(!st_m));
          chk($sformatf("d%0d_vld", g), 32'(vout[g]), 32'(st_m));
          if (st_m) begin
            chk($sformatf("d%0d_q_size", g), 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) chk($sformatf("d%0d_hv", g), 32'(hv[g]), 32'(exp_q[0]));
            if (rin[g]) begin
              if (exp_q.size() > 0) void'(exp_q.pop_front());
              st_m = 1'b0;
            end
          end else if (vin[g]) begin
            acc_m = rho8(acc_m) ^ maj8(m1[g], m2[g], m3[g]);
            if (cnt_m == N - 1) begin
              exp_q.push_back(acc_m);
              acc_m = '0;
              cnt_m = 0;
              st_m  = 1'b1;
            end else begin
              cnt_m++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [0:D-1] a,
                       input logic [0:D-1] b, input logic [0:D-1] c);
    vin[d] = v;
    m1[d]  = a;
    m2[d]  = b;
    m3[d]  = c;
  endtask

  task automatic drive_f(input int d, input logic [0:D-1] f);
    drive(d, 1'b1, f, f, f);
  endtask

  task automatic drive_rand(input int d, input logic v);
    drive(d, v, D'($urandom), D'($urandom), D'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_out;
    int pending;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rin[d] = 1'b1;
      drive(d, 1'b0, '0, '0, '0);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Majority fusion with a 1-sample window.
    drive(0, 1'b1, 8'b11000000, 8'b10100000, 8'b01100000);
    step();
    drive(0, 1'b0, '0, '0, '0);
    chk("maj_vld", 32'(vout[0]), 32'd1);
    chk("maj_out", 32'(hv[0]), 32'(8'b11100000));
    step();
    step();

    // Temporal order with a 3-sample window.
    drive_f(2, 8'b10000000);
    step();
    drive_f(2, 8'b00000000);
    step();
    drive_f(2, 8'b00000000);
    step();
    drive(2, 1'b0, '0, '0, '0);
    chk("order_vld", 32'(vout[2]), 32'd1);
    chk("order_out", 32'(hv[2]), 32'(8'b00100000));
    step();

    // Rotation wrap-around with a 2-sample window.
    drive_f(1, 8'b00000001);
    step();
    drive_f(1, 8'b00000001);
    step();
    drive(1, 1'b0, '0, '0, '0);
    chk("wrap_vld", 32'(vout[1]), 32'd1);
    chk("wrap_out", 32'(hv[1]), 32'(8'b10000001));
    step();

    // Backpressure: downstream stalls while upstream keeps offering changing data.
    rin[2] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_rand(2, 1'b1);
      step();
    end
    chk("bp_rdy_low", 32'(rdy[2]), 32'd0);
    rin[2] = 1'b1;
    drive_rand(2, 1'b1);
    step();
    chk("bp_rdy_back", 32'(rdy[2]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_rand(2, 1'b1);
      step();
    end
    drive(2, 1'b0, '0, '0, '0);
    step();
    step();

    // Reset in the middle of a window.
    drive_rand(2, 1'b1);
    step();
    drive_rand(2, 1'b1);
    step();
    drive(2, 1'b0, '0, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("arst_rdy%0d", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("arst_vld%0d", d), 32'(vout[d]), 32'd0);
      chk($sformatf("arst_hv%0d", d), 32'(hv[d]), 32'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive_f(2, 8'b10000000);
    step();
    drive_f(2, 8'b00000000);
    step();
    drive_f(2, 8'b00000000);
    step();
    drive(2, 1'b0, '0, '0, '0);
    chk("rst_win_vld", 32'(vout[2]), 32'd1);
    chk("rst_win_out", 32'(hv[2]), 32'(8'b00100000));
    step();
    step();

    // Streaming: back-to-back windows with the output always taken.
    n_out = 0;
    for (int c = 0; c < 16; c++) begin
      for (int d = 0; d < 3; d++) drive_rand(d, 1'b1);
      step();
      if (vout[2]) n_out++;
    end
    for (int d = 0; d < 3; d++) drive(d, 1'b0, '0, '0, '0);
    chk("stream_outputs", 32'(n_out), 32'd4);
    step();

    // Random valid and ready on all instances.
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 3; d++) begin
        drive_rand(d, 1'($urandom_range(0, 3) != 0));
        rin[d] = 1'($urandom_range(0, 2) != 0);
      end
      step();
    end

    // Drain whatever is still pending, within a bounded number of cycles.
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, '0, '0, '0);
      rin[d] = 1'b1;
    end
    pending = 1;
    for (int c = 0; c < 20 && pending != 0; c++) begin
      step();
      pending = gen_dut[0].exp_q.size() + gen_dut[1].exp_q.size() + gen_dut[2].exp_q.size();
    end
    chk("drain_pending", 32'(pending), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
